// File: rtl/mod_counter.sv
// Parameterised up/down counter with prescaler, terminal-count pulse and
// wrap, saturate or one-shot behaviour at the terminal value.
module mod_counter #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned STOP     = 2,
  parameter int unsigned MODE     = 0,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             UP,
  input  logic             START,
  output logic [WIDTH-1:0] out,
  output logic             TC,
  output logic             BUSY
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PreLast = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] StopV   = WIDTH'(STOP);
  localparam bit               OneShot = (MODE == 2);
  localparam bit               Wrap    = (MODE == 0);

  // Declaration initialisers give the same power-up state as CLR.
  logic [PW-1:0]    pre_q = '0;
  logic [WIDTH-1:0] cnt_q = '0;
  logic             tc_q  = 1'b0;
  logic             busy_q = 1'b0;

  logic [PW-1:0]    pre_d;
  logic [WIDTH-1:0] cnt_d;
  logic             tc_d;
  logic             busy_d;
  logic [WIDTH-1:0] term;
  logic             step;

  always_comb begin
    term   = UP ? StopV : '0;
    step   = EN && (pre_q == PreLast);
    cnt_d  = cnt_q;
    pre_d  = pre_q;
    tc_d   = 1'b0;
    busy_d = busy_q;
    if (LOAD) begin
      cnt_d  = (D > StopV) ? StopV : D;
      pre_d  = '0;
      busy_d = 1'b0;
    end else if (OneShot && START && !busy_q) begin
      cnt_d  = UP ? '0 : StopV;
      pre_d  = '0;
      busy_d = 1'b1;
    end else if (EN) begin
      pre_d = step ? '0 : pre_q + 1'b1;
      // An idle one-shot lets the prescaler run but never moves the count.
      if (step && (!OneShot || busy_q)) begin
        if (cnt_q != term) begin
          cnt_d = UP ? cnt_q + 1'b1 : cnt_q - 1'b1;
          tc_d  = (cnt_d == term);
        end else if (Wrap) begin
          cnt_d = UP ? '0 : StopV;
          tc_d  = (cnt_d == term);
        end
        if (OneShot && (cnt_d == term)) begin
          busy_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      busy_q <= busy_d;
    end
  end

  assign out  = cnt_q;
  assign TC   = tc_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_mod_counter.sv
// Drives six differently parameterised counters with shared stimulus and checks
// them every cycle against a behavioural model, plus directed literal checks.
module tb_mod_counter;

  localparam int N = 6;
  localparam int WS [N] = '{3, 4, 4, 3, 3, 3};
  localparam int SS [N] = '{2, 9, 9, 4, 0, 5};
  localparam int MS [N] = '{0, 1, 0, 2, 0, 2};
  localparam int PS [N] = '{1, 1, 3, 1, 2, 3};

  typedef struct packed {
    logic [31:0] out;
    logic [31:0] pre;
    logic        tc;
    logic        busy;
  } mstate_t;

  logic       CLK = 1'b0;
  logic       CLR, EN, LOAD, UP, START;
  logic [3:0] D;

  logic [31:0] outs  [N];
  logic        tcs   [N];
  logic        busys [N];
  mstate_t     ms    [N];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [WS[g]-1:0] o;
    logic             tc;
    logic             busy;
    mod_counter #(
      .WIDTH   (WS[g]),
      .STOP    (SS[g]),
      .MODE    (MS[g]),
      .PRESCALE(PS[g])
    ) u_dut (
      .CLK  (CLK),
      .CLR  (CLR),
      .EN   (EN),
      .LOAD (LOAD),
      .D    (D[WS[g]-1:0]),
      .UP   (UP),
      .START(START),
      .out  (o),
      .TC   (tc),
      .BUSY (busy)
    );
    assign outs[g]  = 32'(o);
    assign tcs[g]   = tc;
    assign busys[g] = busy;
  end

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%0d want=%0d at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Next state from the rules: priority clr > load > start > step.
  function automatic mstate_t mstep(input int stop, input int mode, input int pres,
                                    input mstate_t s, input bit clr, input bit en,
                                    input bit load, input bit up, input bit start,
                                    input int d);
    mstate_t n;
    int t;
    int o;
    n    = s;
    n.tc = 1'b0;
    t    = up ? stop : 0;
    o    = int'(s.out);
    if (clr) begin
      n = '0;
    end else if (load) begin
      n.out  = (d > stop) ? stop : d;
      n.pre  = 0;
      n.busy = 1'b0;
    end else if (mode == 2 && start && !s.busy) begin
      n.out  = up ? 0 : stop;
      n.pre  = 0;
      n.busy = 1'b1;
    end else if (en) begin
      n.pre = (int'(s.pre) + 1) % pres;
      if (int'(s.pre) == pres - 1 && (mode != 2 || s.busy)) begin
        if (o != t) begin
          o    = up ? o + 1 : o - 1;
          n.tc = (o == t);
        end else if (mode == 0) begin
          o    = up ? 0 : stop;
          n.tc = (o == t);
        end
        n.out = o;
        if (mode == 2 && o == t) n.busy = 1'b0;
      end
    end
    return n;
  endfunction

  initial begin
    for (int g = 0; g < N; g++) ms[g] = '0;
    forever begin
      @(posedge CLK);
      for (int g = 0; g < N; g++) begin
        ms[g] = mstep(SS[g], MS[g], PS[g], ms[g], CLR, EN, LOAD, UP, START,
                      int'(D) & ((1 << WS[g]) - 1));
      end
      #2;
      for (int g = 0; g < N; g++) begin
        chk("model_out", g, int'(outs[g]), int'(ms[g].out));
        chk("model_tc", g, int'(tcs[g]), int'(ms[g].tc));
        chk("model_busy", g, int'(busys[g]), int'(ms[g].busy));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #3;
  endtask

  initial begin
    CLR = 1'b0; EN = 1'b0; LOAD = 1'b0; UP = 1'b1; START = 1'b0; D = '0;
    #2;
    for (int g = 0; g < N; g++) begin
      chk("powerup_out", g, int'(outs[g]), 0);
      chk("powerup_busy", g, int'(busys[g]), 0);
    end

    // Default wrap counter: 1,2,0,1,2,0,1 with TC where out becomes 2.
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("clr_out", 0, int'(outs[0]), 0);
    EN = 1'b1; UP = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("wrap_out", 0, int'(outs[0]), k % 3);
      chk("wrap_tc", 0, int'(tcs[0]), (k % 3 == 2) ? 1 : 0);
    end

    // Saturating down counter, load clamps to STOP.
    UP = 1'b0; LOAD = 1'b1; D = 4'd15; tick(); LOAD = 1'b0;
    chk("sat_load", 1, int'(outs[1]), 9);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("sat_out", 1, int'(outs[1]), (9 - k > 0) ? 9 - k : 0);
      chk("sat_tc", 1, int'(tcs[1]), (k == 9) ? 1 : 0);
    end

    // Prescale 3, then EN low for 2 cycles mid-prescale delays the step by 2.
    CLR = 1'b1; tick(); CLR = 1'b0; UP = 1'b1; EN = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("pre_out", 2, int'(outs[2]), k / 3);
    end
    EN = 1'b0; tick(); tick();
    chk("pre_frozen", 2, int'(outs[2]), 2);
    EN = 1'b1; tick();
    chk("pre_delay", 2, int'(outs[2]), 2);
    tick();
    chk("pre_step", 2, int'(outs[2]), 3);

    // One-shot with STOP=4.
    CLR = 1'b1; tick(); CLR = 1'b0;
    EN = 1'b1; UP = 1'b1; START = 1'b1; tick(); START = 1'b0;
    chk("os_start_out", 3, int'(outs[3]), 0);
    chk("os_start_busy", 3, int'(busys[3]), 1);
    tick(); chk("os_out1", 3, int'(outs[3]), 1);
    tick(); chk("os_out2", 3, int'(outs[3]), 2);
    START = 1'b1; tick(); START = 1'b0;
    chk("os_ignore_out", 3, int'(outs[3]), 3);
    chk("os_ignore_busy", 3, int'(busys[3]), 1);
    tick();
    chk("os_end_out", 3, int'(outs[3]), 4);
    chk("os_end_tc", 3, int'(tcs[3]), 1);
    chk("os_end_busy", 3, int'(busys[3]), 0);
    tick();
    chk("os_idle_out", 3, int'(outs[3]), 4);
    chk("os_idle_tc", 3, int'(tcs[3]), 0);
    START = 1'b1; tick(); START = 1'b0;
    chk("os_restart", 3, int'(outs[3]), 0);
    chk("os_restart_busy", 3, int'(busys[3]), 1);
    tick(); chk("os_restart1", 3, int'(outs[3]), 1);

    // Priority: CLR over LOAD and START, then LOAD over START.
    CLR = 1'b1; LOAD = 1'b1; START = 1'b1; D = 4'd7; tick(); CLR = 1'b0;
    for (int g = 0; g < N; g++) begin
      chk("prio_clr_out", g, int'(outs[g]), 0);
      chk("prio_clr_busy", g, int'(busys[g]), 0);
    end
    tick(); LOAD = 1'b0; START = 1'b0;
    chk("prio_load_out", 3, int'(outs[3]), 4);
    chk("prio_load_busy", 3, int'(busys[3]), 0);

    // Direction reversal at out=1 on the default counter.
    CLR = 1'b1; tick(); CLR = 1'b0; UP = 1'b1; EN = 1'b1;
    tick(); chk("rev_out1", 0, int'(outs[0]), 1);
    UP = 1'b0;
    tick();
    chk("rev_out0", 0, int'(outs[0]), 0);
    chk("rev_tc", 0, int'(tcs[0]), 1);
    tick();
    chk("rev_wrap", 0, int'(outs[0]), 2);
    chk("rev_wrap_tc", 0, int'(tcs[0]), 0);

    // Randomised traffic, checked by the per-cycle model comparison.
    for (int k = 0; k < 3000; k++) begin
      CLR   = ($urandom_range(0, 59) == 0);
      LOAD  = ($urandom_range(0, 24) == 0);
      START = ($urandom_range(0, 7) == 0);
      EN    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) UP = ~UP;
      D     = 4'($urandom_range(0, 15));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
